// File: rtl/instr_fetch.sv
// instr_fetch: LEGv8 fetch stage owning the PC and the IF/ID register; `define FETCH_HALT_EN to stop fetching on HALT_WORD
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] HALT_WORD = 32'hD600_03E0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus4,
  output logic        if_valid,
  output logic        halted
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  logic [15:0] pc_q, pc_d, pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [15:0] ifpc_q, ifpc_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [0:0]  state_q, state_d;
  logic        halt_hit;
  logic        unused_target;
  assign unused_target = ^br_target[1:0];
  assign pc_plus4 = pc_q + 16'd4;
`ifdef FETCH_HALT_EN
  assign halt_hit = (rom_data == HALT_WORD) && !flush;
`else
  logic unused_halt_word;
  assign unused_halt_word = ^HALT_WORD;
  assign halt_hit = 1'b0;
`endif
  // next-state selection: branch beats stall, stall beats halt, halt beats advance
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    state_d = state_q;
    if (br_taken) begin
      pc_d    = {br_target[15:2], 2'b00};
      valid_d = 1'b0;
      state_d = RUN;
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end else begin
      instr_d = rom_data;
      ifpc_d  = pc_q;
      pc4_d   = pc_plus4;
      valid_d = !flush;
      pc_d    = halt_hit ? pc_q : pc_plus4;
      state_d = halt_hit ? HALT : RUN;
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= {RESET_PC[15:2], 2'b00};
      instr_q <= '0;
      ifpc_q  <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end
  assign rom_addr    = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = ifpc_q;
  assign if_pc_plus4 = pc4_q;
  assign if_valid    = valid_q;
  assign halted      = (state_q == HALT);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random checks of instr_fetch against a behavioural fetch model
module tb_instr_fetch;
  localparam logic [31:0] HW = 32'hD600_03E0;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, flush = 1'b0, br_taken = 1'b0;
  logic [15:0] br_target = '0;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_instr;
  logic [15:0] if_pc, if_pc_plus4;
  logic        if_valid, halted;
  int total = 0, bad = 0;
  logic [15:0] m_pc, m_ifpc, m_pc4;
  logic [31:0] m_instr;
  logic        m_valid, m_halt;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .br_taken(br_taken),
    .br_target(br_target), .rom_addr(rom_addr), .rom_data(rom_data), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [15:0] a);
    return (a == 16'h0048) ? HW : {16'h0000, a};
  endfunction
  assign rom_data = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic b, input logic [15:0] t);
    logic [31:0] w;
    rst_n = r; stall = s; flush = f; br_taken = b; br_target = t;
    w = rom_fn(m_pc);
    if (!r) begin
      m_pc = 16'h0000; m_instr = '0; m_ifpc = '0; m_pc4 = '0; m_valid = 1'b0; m_halt = 1'b0;
    end else if (b) begin
      m_pc = {t[15:2], 2'b00}; m_valid = 1'b0; m_halt = 1'b0;
    end else if (s) begin
      m_valid = m_valid;
    end else if (m_halt) begin
      m_valid = 1'b0;
    end else begin
      m_instr = w; m_ifpc = m_pc; m_pc4 = m_pc + 16'd4; m_valid = !f;
      if (HALT_EN && w == HW && !f) m_halt = 1'b1;
      else m_pc = m_pc + 16'd4;
    end
    @(posedge clk); #1;
    chk("rom_addr", {16'h0, rom_addr}, {16'h0, m_pc});
    chk("if_valid", {31'h0, if_valid}, {31'h0, m_valid});
    chk("halted", {31'h0, halted}, {31'h0, m_halt});
    if (m_valid || !r) begin
      chk("if_instr", if_instr, m_instr);
      chk("if_pc", {16'h0, if_pc}, {16'h0, m_ifpc});
      chk("if_pc_plus4", {16'h0, if_pc_plus4}, {16'h0, m_pc4});
    end
  endtask

  initial begin
    m_pc = '0; m_instr = '0; m_ifpc = '0; m_pc4 = '0; m_valid = 1'b0; m_halt = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h0);
    chk("pc_at_0x10", {16'h0, rom_addr}, 32'h0010);
    step(1, 0, 0, 1, 16'h0043);
    chk("branch_bubble", {31'h0, if_valid}, 32'h0);
    chk("branch_pc", {16'h0, rom_addr}, 32'h0040);
    step(1, 0, 0, 0, 16'h0);
    chk("branch_target_pc", {16'h0, if_pc}, 32'h0040);
    step(1, 0, 0, 1, 16'h0008);
    step(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, 0, 16'h0);
      chk("stall_if_pc", {16'h0, if_pc}, 32'h0008);
      chk("stall_rom_addr", {16'h0, rom_addr}, 32'h000C);
    end
    step(1, 1, 0, 1, 16'h0014);
    chk("stall_branch_valid", {31'h0, if_valid}, 32'h0);
    step(1, 0, 1, 0, 16'h0);
    chk("flush_valid", {31'h0, if_valid}, 32'h0);
    step(1, 0, 0, 0, 16'h0);
    chk("after_flush_pc", {16'h0, if_pc}, 32'h0018);
    step(1, 0, 0, 1, 16'h0048);
    step(1, 0, 0, 0, 16'h0);
    chk("halt_word_latched", if_instr, HW);
    chk("halt_pc", {16'h0, rom_addr}, HALT_EN ? 32'h0048 : 32'h004C);
    step(1, 1, 0, 0, 16'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'h0000);
    chk("halt_cleared", {31'h0, halted}, 32'h0);
    step(1, 0, 0, 0, 16'h0);
    step(1, 0, 0, 1, 16'hFFFC);
    step(1, 0, 0, 0, 16'h0);
    chk("wrap_pc", {16'h0, if_pc}, 32'hFFFC);
    step(1, 0, 0, 0, 16'h0);
    chk("wrap_zero", {16'h0, if_pc}, 32'h0000);
    step(0, 1, 1, 1, 16'h1234);
    step(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] t;
      t = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h00FF)) : 16'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), t);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
